// File: rtl/dii_package.sv
// Shared DII flit definition used by every debug-interconnect block.
package dii_package;

  localparam int DII_FLIT_W = 18;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

endpackage

// File: rtl/osd_rr_arbiter.sv
// Combinational round-robin pick: the first requester after ptr, searched cyclically,
// returned as a one-hot vector (zero when nothing requests).
module osd_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  sel
);

  logic [PW:0]  shamt;
  logic [N-1:0] rot_req;
  logic [N-1:0] rot_oh;

  // Rotate the doubled request so bit 0 is the port right after ptr, take the lowest set bit,
  // then rotate the one-hot back through a doubled copy.
  always_comb begin
    shamt   = (PW+1)'(ptr) + (PW+1)'(1);
    rot_req = N'({req, req} >> shamt);
    rot_oh  = rot_req & (~rot_req + N'(1));
    sel     = N'(({rot_oh, rot_oh} << shamt) >> N);
  end

endmodule

// File: rtl/osd_dii_egress_arbiter.sv
// Packet-granular round-robin share of one DII egress link among NUM_PORTS sources,
// with a registered output flit.
module osd_dii_egress_arbiter
  import dii_package::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  dii_flit [NUM_PORTS-1:0] in_flit,
  output logic [NUM_PORTS-1:0] in_ready,
  output dii_flit              out_flit,
  input  logic                 out_ready,
  output logic [NUM_PORTS-1:0] grant
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  dii_flit              out_q, out_d;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] arb_sel;
  logic [NUM_PORTS-1:0] cand;
  dii_flit              sel_flit;
  logic                 load_ok;
  logic                 hs;

  function automatic logic [PW-1:0] onehot_idx(input logic [NUM_PORTS-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = PW'(i);
    end
    return idx;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) req[i] = in_flit[i].valid;
  end

  osd_rr_arbiter #(
    .N  (NUM_PORTS),
    .PW (PW)
  ) u_rr (
    .req (req),
    .ptr (ptr_q),
    .sel (arb_sel)
  );

  // Handshake: a flit moves on port i when in_flit[i].valid & in_ready[i] at a clk edge;
  // in_ready never depends on that port's own valid once the port owns the link.
  always_comb begin
    load_ok  = ~out_q.valid | out_ready;
    cand     = (state_q == ST_LOCKED) ? grant_q : arb_sel;
    sel_flit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cand[i]) sel_flit = in_flit[i];
    end
    in_ready = (load_ok && !rst) ? cand : '0;
    hs       = load_ok & sel_flit.valid;

    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    out_d   = out_q;

    if (hs)             out_d       = sel_flit;
    else if (out_ready) out_d.valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          ptr_d = onehot_idx(arb_sel);
          if (!sel_flit.last) begin
            state_d = ST_LOCKED;
            grant_d = arb_sel;
          end
        end
      end
      ST_LOCKED: begin
        if (hs && sel_flit.last) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(NUM_PORTS - 1);
      grant_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      out_q   <= out_d;
    end
  end

  assign out_flit = out_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_osd_dii_egress_arbiter.sv
// Directed and random checks for the DII egress arbiter, four sources.
module tb_osd_dii_egress_arbiter;
  import dii_package::*;

  localparam int NP = 4;

  logic              clk = 1'b0;
  logic              rst;
  dii_flit [NP-1:0]  in_flit;
  logic [NP-1:0]     in_ready;
  dii_flit           out_flit;
  logic              out_ready;
  logic [NP-1:0]     grant;

  int total = 0;
  int bad   = 0;

  logic [16:0] exp_q [NP][$];

  osd_dii_egress_arbiter #(.NUM_PORTS(NP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_ready (out_ready),
    .grant     (grant)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int p, input logic v, input logic l, input logic [15:0] d);
    in_flit[p].valid = v;
    in_flit[p].last  = l;
    in_flit[p].data  = d;
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b0, 16'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0]  vm [5] = '{4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0000};
    logic [3:0]  er [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0000};
    logic        ev [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] ed [5] = '{16'h00A0, 16'h00B0, 16'h00C0, 16'h00A0, 16'h0000};
    rst = 1'b1;
    out_ready = 1'b1;
    idle_all();
    drive(0, 1'b1, 1'b1, 16'h00A0);
    drive(1, 1'b1, 1'b1, 16'h00B0);
    drive(2, 1'b1, 1'b1, 16'h00C0);
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (out_flit.valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_flit.valid); end
    total++;
    if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int r = 0; r < 5; r++) begin
      drive(0, vm[r][0], 1'b1, 16'h00A0);
      drive(1, vm[r][1], 1'b1, 16'h00B0);
      drive(2, vm[r][2], 1'b1, 16'h00C0);
      @(negedge clk);
      total++;
      if (in_ready !== er[r]) begin bad++; $display("FAIL rr_ready row %0d: got %b want %b", r, in_ready, er[r]); end
      @(posedge clk); #1;
      total++;
      if (out_flit.valid !== ev[r] || (ev[r] && out_flit.data !== ed[r])) begin
        bad++; $display("FAIL rr_out row %0d: got v=%b d=%h want v=%b d=%h", r, out_flit.valid, out_flit.data, ev[r], ed[r]);
      end
      total++;
      if (grant !== 4'b0000) begin bad++; $display("FAIL rr_grant row %0d: got %b want 0000", r, grant); end
    end
  endtask

  task automatic test_packet_lock();
    logic [3:0]  vm [6] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0000};
    logic [3:0]  lm [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0000};
    logic [15:0] d1 [6] = '{16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0000, 16'h0000};
    logic [3:0]  er [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0000};
    logic        ev [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] ed [6] = '{16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h000A, 16'h0000};
    logic [3:0]  eg [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    out_ready = 1'b1;
    idle_all();
    for (int r = 0; r < 6; r++) begin
      drive(0, vm[r][0], lm[r][0], 16'h000A);
      drive(1, vm[r][1], lm[r][1], d1[r]);
      @(negedge clk);
      total++;
      if (in_ready !== er[r]) begin bad++; $display("FAIL lock_ready row %0d: got %b want %b", r, in_ready, er[r]); end
      @(posedge clk); #1;
      total++;
      if (out_flit.valid !== ev[r] || (ev[r] && out_flit.data !== ed[r])) begin
        bad++; $display("FAIL lock_out row %0d: got v=%b d=%h want v=%b d=%h", r, out_flit.valid, out_flit.data, ev[r], ed[r]);
      end
      total++;
      if (grant !== eg[r]) begin bad++; $display("FAIL lock_grant row %0d: got %b want %b", r, grant, eg[r]); end
    end
  endtask

  task automatic test_bubble();
    logic [3:0]  vm [8] = '{4'b0111, 4'b0101, 4'b0101, 4'b0101, 4'b0111, 4'b0101, 4'b0001, 4'b0000};
    logic [3:0]  lm [8] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0111, 4'b0101, 4'b0001, 4'b0000};
    logic [15:0] d1 [8] = '{16'h0021, 16'h0000, 16'h0000, 16'h0000, 16'h0022, 16'h0000, 16'h0000, 16'h0000};
    logic [3:0]  er [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0001, 4'b0000};
    logic        ev [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] ed [8] = '{16'h0021, 16'h0000, 16'h0000, 16'h0000, 16'h0022, 16'h002C, 16'h000B, 16'h0000};
    logic [3:0]  eg [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    out_ready = 1'b1;
    idle_all();
    for (int r = 0; r < 8; r++) begin
      drive(0, vm[r][0], lm[r][0], 16'h000B);
      drive(1, vm[r][1], lm[r][1], d1[r]);
      drive(2, vm[r][2], lm[r][2], 16'h002C);
      @(negedge clk);
      total++;
      if (in_ready !== er[r]) begin bad++; $display("FAIL bubble_ready row %0d: got %b want %b", r, in_ready, er[r]); end
      @(posedge clk); #1;
      total++;
      if (out_flit.valid !== ev[r] || (ev[r] && out_flit.data !== ed[r])) begin
        bad++; $display("FAIL bubble_out row %0d: got v=%b d=%h want v=%b d=%h", r, out_flit.valid, out_flit.data, ev[r], ed[r]);
      end
      total++;
      if (grant !== eg[r]) begin bad++; $display("FAIL bubble_grant row %0d: got %b want %b", r, grant, eg[r]); end
    end
  endtask

  task automatic test_backpressure();
    logic        orr [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]  vm  [10] = '{4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0000};
    logic [3:0]  lm  [10] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0100, 4'b0000};
    logic [15:0] d0  [10] = '{16'h1234, 16'h1235, 16'h1235, 16'h1235, 16'h1235, 16'h1235, 16'h1235, 16'h1236, 16'h0000, 16'h0000};
    logic [3:0]  er  [10] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0100, 4'b0000};
    logic        ev  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] ed  [10] = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1235, 16'h1236, 16'h002D, 16'h0000};
    logic [3:0]  eg  [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    idle_all();
    for (int r = 0; r < 10; r++) begin
      out_ready = orr[r];
      drive(0, vm[r][0], lm[r][0], d0[r]);
      drive(2, vm[r][2], lm[r][2], 16'h002D);
      @(negedge clk);
      total++;
      if (in_ready !== er[r]) begin bad++; $display("FAIL bp_ready row %0d: got %b want %b", r, in_ready, er[r]); end
      @(posedge clk); #1;
      total++;
      if (out_flit.valid !== ev[r] || (ev[r] && out_flit.data !== ed[r])) begin
        bad++; $display("FAIL bp_out row %0d: got v=%b d=%h want v=%b d=%h", r, out_flit.valid, out_flit.data, ev[r], ed[r]);
      end
      total++;
      if (grant !== eg[r]) begin bad++; $display("FAIL bp_grant row %0d: got %b want %b", r, grant, eg[r]); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0]  vm [3] = '{4'b1001, 4'b1000, 4'b0000};
    logic [3:0]  er [3] = '{4'b0001, 4'b1000, 4'b0000};
    logic        ev [3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] ed [3] = '{16'h0050, 16'h0033, 16'h0000};
    out_ready = 1'b1;
    idle_all();
    drive(3, 1'b1, 1'b0, 16'h0031);
    @(negedge clk);
    total++;
    if (in_ready !== 4'b1000) begin bad++; $display("FAIL areset_pre_ready: got %b want 1000", in_ready); end
    @(posedge clk); #1;
    total++;
    if (out_flit.valid !== 1'b1 || out_flit.data !== 16'h0031 || grant !== 4'b1000) begin
      bad++; $display("FAIL areset_pre_out: got v=%b d=%h g=%b want v=1 d=0031 g=1000", out_flit.valid, out_flit.data, grant);
    end
    drive(3, 1'b1, 1'b0, 16'h0032);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_flit.valid !== 1'b0) begin bad++; $display("FAIL areset_out_valid: got %b want 0", out_flit.valid); end
    total++;
    if (grant !== 4'b0000) begin bad++; $display("FAIL areset_grant: got %b want 0000", grant); end
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL areset_in_ready: got %b want 0000", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      drive(0, vm[r][0], 1'b1, 16'h0050);
      drive(3, vm[r][3], 1'b1, 16'h0033);
      @(negedge clk);
      total++;
      if (in_ready !== er[r]) begin bad++; $display("FAIL post_reset_ready row %0d: got %b want %b", r, in_ready, er[r]); end
      @(posedge clk); #1;
      total++;
      if (out_flit.valid !== ev[r] || (ev[r] && out_flit.data !== ed[r])) begin
        bad++; $display("FAIL post_reset_out row %0d: got v=%b d=%h want v=%b d=%h", r, out_flit.valid, out_flit.data, ev[r], ed[r]);
      end
    end
  endtask

  task automatic test_random();
    int   len [NP];
    int   fi [NP];
    int   pid [NP];
    bit   act [NP];
    bit   hs_seen [NP];
    int   wait_cnt [NP];
    bit   in_pkt;
    int   cur_own;
    int   op;
    bit   gen_en;
    bit   quiet;
    logic [16:0] ex;
    idle_all();
    out_ready = 1'b1;
    in_pkt  = 1'b0;
    cur_own = 0;
    for (int p = 0; p < NP; p++) begin
      len[p] = 1; fi[p] = 0; pid[p] = 0; act[p] = 1'b0; hs_seen[p] = 1'b0; wait_cnt[p] = 0;
      exp_q[p].delete();
    end
    for (int cyc = 0; cyc < 2600; cyc++) begin
      gen_en = (cyc < 2000);
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
        if (hs_seen[p]) begin
          if (fi[p] == len[p] - 1) begin act[p] = 1'b0; pid[p]++; end
          else fi[p]++;
        end
        if (!act[p] && gen_en && $urandom_range(0, 3) == 0) begin
          len[p] = $urandom_range(1, 8);
          fi[p]  = 0;
          act[p] = 1'b1;
          for (int k = 0; k < len[p]; k++) exp_q[p].push_back({k == len[p] - 1, 2'(p), 10'(pid[p]), 4'(k)});
        end
        drive(p, act[p] && (fi[p] == 0 || $urandom_range(0, 4) != 0), fi[p] == len[p] - 1,
              {2'(p), 10'(pid[p]), 4'(fi[p])});
      end
      out_ready = gen_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      for (int p = 0; p < NP; p++) hs_seen[p] = in_flit[p].valid & in_ready[p];
      for (int q = 0; q < NP; q++) begin
        if (hs_seen[q] && fi[q] == 0) begin
          total++;
          if (wait_cnt[q] > 3) begin bad++; $display("FAIL fairness port %0d: waited %0d packets want <=3", q, wait_cnt[q]); end
          wait_cnt[q] = 0;
          for (int p = 0; p < NP; p++) begin
            if (p != q && act[p] && fi[p] == 0 && in_flit[p].valid) wait_cnt[p]++;
          end
        end
      end
      if (out_flit.valid && out_ready) begin
        op = int'(out_flit.data[15:14]);
        total++;
        if (exp_q[op].size() == 0) begin
          bad++; $display("FAIL rand_unexpected: got d=%h want nothing from port %0d", out_flit.data, op);
        end else begin
          ex = exp_q[op].pop_front();
          if ({out_flit.last, out_flit.data} !== ex) begin
            bad++; $display("FAIL rand_data port %0d: got l=%b d=%h want l=%b d=%h", op, out_flit.last, out_flit.data, ex[16], ex[15:0]);
          end
        end
        total++;
        if (in_pkt && op != cur_own) begin
          bad++; $display("FAIL rand_interleave: got port %0d want port %0d", op, cur_own);
        end
        in_pkt  = !out_flit.last;
        cur_own = op;
      end
      quiet = !gen_en && !out_flit.valid;
      for (int p = 0; p < NP; p++) if (act[p] || exp_q[p].size() != 0) quiet = 1'b0;
      if (quiet) break;
    end
    for (int p = 0; p < NP; p++) begin
      total++;
      if (exp_q[p].size() != 0) begin
        bad++; $display("FAIL rand_leftover port %0d: got %0d flits undelivered want 0", p, exp_q[p].size());
      end
    end
    idle_all();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_packet_lock();
    test_bubble();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
